// File: rtl/seq_scan_ctrl_pkg.sv
// Shared definitions for the frame-level sequence scan controller.
package seq_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_e;

    localparam logic [4:0] DEFAULT_PAT = 5'b11001;

endpackage

// File: rtl/seq_scan_ctrl_if.sv
// Word handshake, configuration and result bundle between producer and scan controller.
interface seq_scan_ctrl_if #(
    parameter int WORD_W = 16,
    parameter int PAT_W  = 5,
    parameter int CNT_W  = 8
);
    logic              cfg_we;
    logic [PAT_W-1:0]  cfg_pat;
    logic              cfg_ovl;
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              in_last;
    logic              bit_out;
    logic              hit;
    logic [CNT_W-1:0]  match_cnt;
    logic              done;
    logic              busy;

    modport master (
        output cfg_we, cfg_pat, cfg_ovl, in_valid, in_data, in_last,
        input  in_ready, bit_out, hit, match_cnt, done, busy
    );

    modport slave (
        input  cfg_we, cfg_pat, cfg_ovl, in_valid, in_data, in_last,
        output in_ready, bit_out, hit, match_cnt, done, busy
    );
endinterface

// File: rtl/seq_match_core.sv
// Serial Mealy pattern matcher: bit history, valid-bit count, hit compare, overlap clear.
module seq_match_core #(
    parameter int PAT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             bit_i,
    input  logic             clr_i,
    input  logic [PAT_W-1:0] pat_i,
    input  logic             ovl_i,
    output logic             hit_o
);
    localparam int            VC_W   = $clog2(PAT_W);
    localparam logic [VC_W-1:0] VC_MAX = VC_W'(PAT_W - 1);

    logic [PAT_W-2:0] hist_q, hist_d;
    logic [VC_W-1:0]  vcnt_q, vcnt_d;
    logic [PAT_W-1:0] window;

    // NOTE: every always_comb output is defaulted first so no path can leave it unassigned (no latch).
    always_comb begin
        window = {hist_q, bit_i};
        hit_o  = en_i && (vcnt_q == VC_MAX) && (window == pat_i);
        hist_d = hist_q;
        vcnt_d = vcnt_q;
        if (clr_i) begin
            hist_d = '0;
            vcnt_d = '0;
        end else if (en_i) begin
            if (hit_o && !ovl_i) begin
                hist_d = '0;
                vcnt_d = '0;
            end else begin
                hist_d = window[PAT_W-2:0];
                if (vcnt_q != VC_MAX) vcnt_d = vcnt_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= '0;
            vcnt_q <= '0;
        end else begin
            hist_q <= hist_d;
            vcnt_q <= vcnt_d;
        end
    end
endmodule

// File: rtl/seq_scan_ctrl.sv
// Frame controller: accepts words, shifts them MSB first into the matcher, counts hits per frame.
module seq_scan_ctrl
    import seq_scan_ctrl_pkg::*;
#(
    parameter int WORD_W = 16,
    parameter int PAT_W  = 5,
    parameter int CNT_W  = 8
) (
    input  logic           clk,
    input  logic           rst,
    seq_scan_ctrl_if.slave bus
);
    localparam int               IDX_W    = $clog2(WORD_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [PAT_W-1:0] RST_PAT  = PAT_W'(DEFAULT_PAT);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              last_q, last_d;
    logic              open_q, open_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic              ovl_q, ovl_d;
    logic              shift_en, bit_cur, hist_clr, hit;

    assign shift_en = (state_q == ST_SHIFT);
    assign bit_cur  = shift_en & shreg_q[WORD_W-1];

    seq_match_core #(.PAT_W(PAT_W)) u_core (
        .clk   (clk),
        .rst   (rst),
        .en_i  (shift_en),
        .bit_i (bit_cur),
        .clr_i (hist_clr),
        .pat_i (pat_q),
        .ovl_i (ovl_q),
        .hit_o (hit)
    );

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        idx_d    = idx_q;
        last_d   = last_q;
        open_d   = open_q;
        cnt_d    = cnt_q;
        pat_d    = pat_q;
        ovl_d    = ovl_q;
        hist_clr = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.cfg_we && !open_q) begin
                    pat_d = bus.cfg_pat;
                    ovl_d = bus.cfg_ovl;
                end
                if (bus.in_valid) begin
                    shreg_d = bus.in_data;
                    last_d  = bus.in_last;
                    idx_d   = '0;
                    state_d = ST_SHIFT;
                    // First word of a frame starts a fresh count and history.
                    if (!open_q) begin
                        cnt_d    = '0;
                        hist_clr = 1'b1;
                        open_d   = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                shreg_d = shreg_q << 1;
                if (hit && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = last_q ? ST_DONE : ST_IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                hist_clr = 1'b1;
                open_d   = 1'b0;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            open_q  <= 1'b0;
            cnt_q   <= '0;
            pat_q   <= RST_PAT;
            ovl_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            open_q  <= open_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            ovl_q   <= ovl_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.bit_out   = bit_cur;
    assign bus.hit       = hit;
    assign bus.match_cnt = cnt_q;
    assign bus.done      = (state_q == ST_DONE);
    assign bus.busy      = (state_q != ST_IDLE) || open_q;
endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed self-checking bench for seq_scan_ctrl: hit positions, counts, handshake, reset, cfg gating.
module tb_seq_scan_ctrl;
    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;
    int   n_fail;

    seq_scan_ctrl_if #(.WORD_W(16), .PAT_W(5), .CNT_W(8)) b1 ();
    seq_scan_ctrl_if #(.WORD_W(16), .PAT_W(5), .CNT_W(2)) b2 ();

    seq_scan_ctrl #(.WORD_W(16), .PAT_W(5), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (b1.slave)
    );

    seq_scan_ctrl #(.WORD_W(16), .PAT_W(5), .CNT_W(2)) dut_sat (
        .clk (clk),
        .rst (rst_n),
        .bus (b2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input logic [4:0] pat, input logic ovl);
        @(negedge clk);
        b1.cfg_we  = 1'b1;
        b1.cfg_pat = pat;
        b1.cfg_ovl = ovl;
        @(negedge clk);
        b1.cfg_we  = 1'b0;
    endtask

    // Sends one word on b1, records the hit strobe and bit_out per bit, then checks frame end.
    task automatic frame_word(input string tag, input logic [15:0] d, input logic last,
                              input logic cfg_pulse, input logic [15:0] exp_hits,
                              input logic [7:0] exp_cnt);
        logic [15:0] hits;
        logic [15:0] bits;
        logic        rdy_seen;
        int          w;
        hits     = '0;
        bits     = '0;
        rdy_seen = 1'b0;
        @(negedge clk);
        b1.in_valid = 1'b1;
        b1.in_data  = d;
        b1.in_last  = last;
        w = 0;
        while (!b1.in_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_ready"}, 32'(b1.in_ready), 32'd1);
        @(posedge clk);
        #1;
        b1.in_valid = 1'b0;
        b1.in_last  = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            hits[k]    = b1.hit;
            bits[15-k] = b1.bit_out;
            rdy_seen   = rdy_seen | b1.in_ready;
            if (cfg_pulse && k == 3) begin
                b1.cfg_we  = 1'b1;
                b1.cfg_pat = 5'b10101;
                b1.cfg_ovl = 1'b1;
            end
            if (cfg_pulse && k == 4) b1.cfg_we = 1'b0;
        end
        check({tag, "_hits"}, 32'(hits), 32'(exp_hits));
        check({tag, "_bits"}, 32'(bits), 32'(d));
        check({tag, "_rdy_low"}, 32'(rdy_seen), 32'd0);
        @(negedge clk);
        check({tag, "_cnt"}, 32'(b1.match_cnt), 32'(exp_cnt));
        if (last) begin
            check({tag, "_done"}, {b1.done, b1.in_ready, b1.busy}, 32'b101);
            @(negedge clk);
            check({tag, "_after"}, {b1.done, b1.in_ready, b1.busy}, 32'b010);
            check({tag, "_hold"}, 32'(b1.match_cnt), 32'(exp_cnt));
        end else begin
            check({tag, "_gap"}, {b1.done, b1.in_ready, b1.busy}, 32'b011);
        end
    endtask

    initial begin
        int sat_hits;
        n_total = 0;
        n_pass  = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        b1.cfg_we = 1'b0; b1.cfg_pat = '0; b1.cfg_ovl = 1'b0;
        b1.in_valid = 1'b0; b1.in_data = '0; b1.in_last = 1'b0;
        b2.cfg_we = 1'b0; b2.cfg_pat = '0; b2.cfg_ovl = 1'b0;
        b2.in_valid = 1'b0; b2.in_data = '0; b2.in_last = 1'b0;
        #1;
        check("rst_outputs", {b1.in_ready, b1.bit_out, b1.hit, b1.done, b1.busy}, 32'b10000);
        check("rst_cnt", 32'(b1.match_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Default pattern 11001, overlapping: C8C8 hits bits 4 and 12.
        frame_word("dflt", 16'hC8C8, 1'b1, 1'b0, 16'h1010, 8'd2);

        // Pattern 10101 on AA00: overlap gives bits 4 and 6, non-overlap bit 4 only.
        set_cfg(5'b10101, 1'b1);
        frame_word("ovl1", 16'hAA00, 1'b1, 1'b0, 16'h0050, 8'd2);
        set_cfg(5'b10101, 1'b0);
        frame_word("ovl0", 16'hAA00, 1'b1, 1'b0, 16'h0010, 8'd1);

        // Reset mid-SHIFT after one counted hit; cfg must fall back to 11001 / overlap.
        @(negedge clk);
        b1.in_valid = 1'b1;
        b1.in_data  = 16'hAA00;
        b1.in_last  = 1'b1;
        @(posedge clk);
        #1;
        b1.in_valid = 1'b0;
        b1.in_last  = 1'b0;
        repeat (7) @(negedge clk);
        check("pre_rst_cnt", 32'(b1.match_cnt), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", {b1.in_ready, b1.bit_out, b1.hit, b1.done, b1.busy}, 32'b10000);
        check("midrst_cnt", 32'(b1.match_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        frame_word("postrst", 16'hC8C8, 1'b1, 1'b0, 16'h1010, 8'd2);

        // Two-word frame: history carries across the word boundary.
        frame_word("w1", 16'h0003, 1'b0, 1'b0, 16'h0000, 8'd0);
        frame_word("w2", 16'h2000, 1'b1, 1'b0, 16'h0004, 8'd1);

        // cfg write during SHIFT is ignored; in IDLE it applies to the next frame.
        frame_word("cfgshift", 16'hC8C8, 1'b1, 1'b1, 16'h1010, 8'd2);
        set_cfg(5'b10101, 1'b1);
        frame_word("cfgidle", 16'hAA00, 1'b1, 1'b0, 16'h0050, 8'd2);

        // Narrow counter saturates at 3 while 12 hit strobes occur.
        @(negedge clk);
        b2.cfg_we  = 1'b1;
        b2.cfg_pat = 5'b11111;
        b2.cfg_ovl = 1'b1;
        @(negedge clk);
        b2.cfg_we   = 1'b0;
        b2.in_valid = 1'b1;
        b2.in_data  = 16'hFFFF;
        b2.in_last  = 1'b1;
        @(posedge clk);
        #1;
        b2.in_valid = 1'b0;
        b2.in_last  = 1'b0;
        sat_hits = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (b2.hit) sat_hits++;
        end
        check("sat_strobes", 32'(sat_hits), 32'd12);
        @(negedge clk);
        check("sat_done", 32'(b2.done), 32'd1);
        check("sat_cnt", 32'(b2.match_cnt), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/seq_scan_ctrl.md
# seq_scan_ctrl

Frame-level controller that serialises parallel words into a programmable Mealy sequence-matcher and counts pattern hits per frame. Owns the valid/ready word handshake, the bit-shift schedule, detector history across word boundaries and the per-frame result. Sits between a word-oriented producer and the serial sequence-detection datapath (default pattern 11001).

## Interface
- WORD_W, 16, bits per input word, shifted MSB first
- PAT_W, 5, pattern length in bits
- CNT_W, 8, match counter width (saturating)

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- cfg_we  in  1  load cfg_pat/cfg_ovl; honoured only in IDLE with no frame open
- cfg_pat  in  PAT_W  pattern, MSB = first bit expected; reset value 5'b11001 (PAT_W=5)
- cfg_ovl  in  1  1 = overlapping matches, 0 = history cleared after each hit; reset 1
- in_valid  in  1  word available
- in_ready  out  1  controller accepts word
- in_data  in  WORD_W  word to scan
- in_last  in  1  word closes the frame
- bit_out  out  1  bit currently presented to matcher
- hit  out  1  Mealy strobe: current bit completes pattern
- match_cnt  out  CNT_W  hits in current/last frame
- done  out  1  one-cycle pulse, frame finished, match_cnt final
- busy  out  1  SHIFT or DONE, or frame open

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid&in_ready: load shift register, latch in_last, bit index=0, -> SHIFT. If no frame open, clear match_cnt and history, set frame_open.
- SHIFT: bit_out = shreg MSB; one bit per cycle; hit evaluated combinationally from history and bit_out. After bit WORD_W-1: latched last=0 -> IDLE (history kept); last=1 -> DONE.
- DONE: done=1 for one cycle, history cleared, frame_open cleared, -> IDLE. match_cnt holds until the next frame's first word is accepted.
- hit = (valid history >= PAT_W-1) and {history[PAT_W-2:0], bit_out} == cfg_pat. Valid-count saturates at PAT_W-1.
- On hit: match_cnt += 1, saturating at 2^CNT_W-1. If cfg_ovl=0, history and valid-count clear on the same edge.
- cfg_we outside IDLE/no-frame: ignored, no side effects.
- Reset (any state, incl. mid-frame): state IDLE, in_ready=1 after release, bit_out=0, hit=0, match_cnt=0, done=0, busy=0, history cleared, cfg to reset values.

## Timing
- Word accepted at edge t; bits presented cycles t+1..t+WORD_W; hit for bit k valid in cycle t+1+k.
- in_ready low from t+1 through last SHIFT cycle; throughput one word per WORD_W+1 cycles.
- Last word: done high in cycle t+WORD_W+1; in_ready high again one cycle later.
- match_cnt updates on the edge ending the hit cycle.
- hit is combinational from registered history, cfg and shreg; no input-to-output combinational path.

## Structure
- Shared package: state enum (IDLE/SHIFT/DONE), default pattern constant 5'b11001.
- Sub-module seq_match_core: history register, valid-count, hit compare, overlap clear; ports clk, rst, en, bit, clr, pat, ovl, hit.
- Top holds FSM, shift register, bit index, match counter, handshake.

## Test plan
- Default cfg, single word 16'hC8C8, in_last=1 -> hit at bits 4 and 12, done one cycle after bit 15, match_cnt=2.
- cfg_pat=10101, word 16'hAA00: cfg_ovl=1 -> hits at bits 4 and 6, match_cnt=2; cfg_ovl=0 -> hit at bit 4 only, match_cnt=1.
- Two-word frame 16'h0003 (last=0) then 16'h2000 (last=1), default pattern -> single hit at word-2 bit 2, match_cnt=1; in_ready high between words.
- CNT_W=2, cfg_pat=11111, cfg_ovl=1, word 16'hFFFF -> 12 hit strobes, match_cnt saturates at 3.
- Reset asserted mid-SHIFT with one hit counted -> all outputs at reset values immediately; next frame 16'hC8C8 yields match_cnt=2 with no carried history.
- cfg_we pulsed during SHIFT with 10101 -> ignored, frame still matches 11001; applied in IDLE -> takes effect next frame.
